regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Write-back controller that shares the register file's single write port (WriteReg/WD/RorW) between two producers.
  - Requester A: single-cycle ALU result.
  - Requester B: multi-cycle unit result (load / mult-div).
- Arbitrates with A-priority plus a starvation guard for B, drops writes to $0, and registers the winning write onto the port.
- Sits between the execute/memory stages and the register file, driving its write inputs directly.

Parameters:
- MAX_WAIT, 3: consecutive lost-conflict cycles for B before B is forced to win (legal range 1..15).
- CNT_W, 4: width of the starvation counter; must hold MAX_WAIT.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- a_valid  input  1  A has a write pending
- a_ready  output  1  A write accepted this cycle (combinational)
- a_reg  input  5  A destination register
- a_data  input  32  A write data
- b_valid  input  1  B has a write pending
- b_ready  output  1  B write accepted this cycle (combinational)
- b_reg  input  5  B destination register
- b_data  input  32  B write data
- WriteReg  output  5  register-file write address (registered)
- WD  output  32  register-file write data (registered)
- RorW  output  1  register-file write enable (registered)
- starving  output  1  high while in state STARVE (registered)

Behaviour:
- Handshake
  - Transfer = valid & ready.
  - Once valid rises, reg/data hold stable until accepted; valid never drops before ready.
- Discard of $0
  - A request with reg==0 gets ready=1 in the same cycle it is valid.
  - It never occupies the port, does not change the counter or state, and produces no write.
- Real requests (reg!=0) compete; at most one real grant per cycle.
  - Only one valid: it is granted.
  - Both valid, state NORMAL: A granted.
  - Both valid, state STARVE: B granted.
- State machine: NORMAL (reset state) and STARVE.
  - Counter cnt: increments (saturating at MAX_WAIT) each cycle B is real-valid and not granted.
  - cnt clears to 0 when B is granted.
  - NORMAL -> STARVE when the incremented cnt equals MAX_WAIT.
  - STARVE -> NORMAL on a B grant.
  - In STARVE with B idle: stay in STARVE; A is granted normally.
- Output register
  - On the edge ending the grant cycle: RorW<=1, WriteReg<=granted reg, WD<=granted data.
  - If no real grant: RorW<=0; WriteReg/WD hold their previous values.
  - The register file commits on the following edge, so acceptance to architectural update takes 2 rising edges.
  - Full throughput: one write per cycle, back to back.
- Ordering: if A and B target the same register in the same cycle, the later grant wins in the file. No reordering within a requester.
- Reset
  - Asynchronously forces RorW=0, WriteReg=0, WD=0, starving=0, cnt=0, state NORMAL.
  - A registered but uncommitted write is lost.
  - a_ready and b_ready are 0 while reset is high.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined, adds ports:
  - A1, A2: input 5, read addresses.
  - RD1_in, RD2_in: input 32, from the register file.
  - RD1_out, RD2_out: output 32.
- Bypass rule: RD1_out = (A1!=0 && RorW && WriteReg==A1) ? WD : RD1_in, and likewise for port 2. This returns the write being committed this cycle instead of the stale file value.
- When undefined: the ports are absent and readers take the register-file outputs directly.

Test Plan:
1. After reset, A-only: a_valid=1, a_reg=5, a_data=0x11 -> a_ready=1 same cycle; next cycle RorW=1, WriteReg=5, WD=0x11; after one more edge, file reg5=0x11.
2. Conflict with MAX_WAIT=3: A and B valid every cycle (a_reg=2, b_reg=3) -> A granted on cycles 0, 1, 2 (cnt 1, 2, 3), starving=1 from cycle 3, B granted on cycle 3; back to NORMAL with cnt=0, and A granted on cycle 4.
3. Zero discard: b_valid=1, b_reg=0 together with a_valid=1, a_reg=7 -> both readies=1 same cycle; only reg7 written; cnt stays 0.
4. Reset mid-operation: assert reset while RorW=1 -> RorW drops to 0 immediately (before next edge); no file write; starving=0.
5. Back-to-back: A valid 4 consecutive cycles with regs 1..4 -> RorW high for 4 consecutive cycles, WriteReg 1, 2, 3, 4 in order.
6. WB_BYPASS_EN: RorW=1, WriteReg=9, WD=0xABCD, A1=9, RD1_in=0 -> RD1_out=0xABCD; with A1=0 -> RD1_out=RD1_in.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the two write-back requesters and the register-file write port.
// Define WB_BYPASS_EN to add the read-bypass address and data signals.
interface regfile_wb_arbiter_if;
  // valid/ready: a transfer happens on a cycle where valid & ready are both high.
  // reg/data stay stable from the rise of valid until that transfer.
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic [4:0]  WriteReg;
  logic [31:0] WD;
  logic        RorW;
  logic        starving;
`ifdef WB_BYPASS_EN
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1_in;
  logic [31:0] RD2_in;
  logic [31:0] RD1_out;
  logic [31:0] RD2_out;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data, A1, A2, RD1_in, RD2_in,
    input  a_ready, b_ready, WriteReg, WD, RorW, starving, RD1_out, RD2_out
  );
  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, A1, A2, RD1_in, RD2_in,
    output a_ready, b_ready, WriteReg, WD, RorW, starving, RD1_out, RD2_out
  );
`else
  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, WriteReg, WD, RorW, starving
  );
  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, WriteReg, WD, RorW, starving
  );
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between an ALU (A) and a multi-cycle unit (B).
// A has priority, with a starvation guard for B. Optional macro WB_BYPASS_EN adds the read bypass.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 4
) (
  input logic                clk,
  input logic                reset,
  regfile_wb_arbiter_if.slave wb
);
  localparam logic [0:0]       S_NORMAL = 1'b0;
  localparam logic [0:0]       S_STARVE = 1'b1;
  localparam logic [CNT_W-1:0] C_MAX    = CNT_W'(MAX_WAIT);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_a_real;
  logic             w_b_real;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             r_rorw;
  logic [4:0]       r_wreg;
  logic [31:0]      r_wd;

  // Writes to $0 are acknowledged immediately but never compete for the port.
  assign w_a_real  = wb.a_valid && (wb.a_reg != 5'd0);
  assign w_b_real  = wb.b_valid && (wb.b_reg != 5'd0);
  assign w_grant_a = w_a_real && (!w_b_real || (r_state == S_NORMAL));
  assign w_grant_b = w_b_real && (!w_a_real || (r_state == S_STARVE));

  assign wb.a_ready = !reset && wb.a_valid && ((wb.a_reg == 5'd0) || w_grant_a);
  assign wb.b_ready = !reset && wb.b_valid && ((wb.b_reg == 5'd0) || w_grant_b);

  assign w_cnt_inc = (r_cnt == C_MAX) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    if (w_grant_b) begin
      w_cnt_nxt   = '0;
      w_state_nxt = S_NORMAL;
    end else if (w_b_real) begin
      w_cnt_nxt = w_cnt_inc;
      if ((r_state == S_NORMAL) && (w_cnt_inc == C_MAX)) begin
        w_state_nxt = S_STARVE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_NORMAL;
      r_cnt   <= '0;
      r_rorw  <= 1'b0;
      r_wreg  <= 5'd0;
      r_wd    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rorw  <= w_grant_a || w_grant_b;
      // Address/data hold when idle so the port only toggles on real writes.
      if (w_grant_a) begin
        r_wreg <= wb.a_reg;
        r_wd   <= wb.a_data;
      end else if (w_grant_b) begin
        r_wreg <= wb.b_reg;
        r_wd   <= wb.b_data;
      end
    end
  end

  assign wb.RorW     = r_rorw;
  assign wb.WriteReg = r_wreg;
  assign wb.WD       = r_wd;
  assign wb.starving = (r_state == S_STARVE);

`ifdef WB_BYPASS_EN
  // Forward the write being committed this cycle over the stale file contents.
  assign wb.RD1_out = ((wb.A1 != 5'd0) && r_rorw && (r_wreg == wb.A1)) ? r_wd : wb.RD1_in;
  assign wb.RD2_out = ((wb.A2 != 5'd0) && r_rorw && (r_wreg == wb.A2)) ? r_wd : wb.RD2_in;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: arbitration model plus a write scoreboard and a register-file model.
module tb_regfile_wb_arbiter;
  localparam int MAX_WAIT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if wb();

  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb.slave)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [36:0] exp_q[$];
  logic [31:0] rf[32];
  int          m_cnt;
  logic        m_starve;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // One arbitration cycle: drive at negedge, check readies, push expected writes.
  task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd,
                       output logic ga, output logic gb, output logic oa, output logic ob);
    logic a_real, b_real, ma, mb;
    @(negedge clk);
    wb.a_valid = av; wb.a_reg = ar; wb.a_data = ad;
    wb.b_valid = bv; wb.b_reg = br; wb.b_data = bd;
    #1;
    a_real = av && (ar != 0);
    b_real = bv && (br != 0);
    ma = a_real && (!b_real || !m_starve);
    mb = b_real && (!a_real || m_starve);
    ga = av && ((ar == 0) || ma);
    gb = bv && ((br == 0) || mb);
    oa = wb.a_ready;
    ob = wb.b_ready;
    check("a_ready", oa, ga);
    check("b_ready", ob, gb);
    if (ma) exp_q.push_back({ar, ad});
    if (mb) exp_q.push_back({br, bd});
    if (mb) begin
      m_cnt = 0; m_starve = 1'b0;
    end else if (b_real) begin
      if (m_cnt < MAX_WAIT) m_cnt++;
      if (m_cnt == MAX_WAIT) m_starve = 1'b1;
    end
  endtask

  task automatic idle();
    logic ga, gb, oa, ob;
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ga, gb, oa, ob);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0;
    m_starve = 1'b0;
    wb.a_valid = 1'b0; wb.a_reg = 5'd0; wb.a_data = 32'd0;
    wb.b_valid = 1'b0; wb.b_reg = 5'd0; wb.b_data = 32'd0;
  endtask

  // Scoreboard: every registered write must match the oldest expected grant.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      check("starving", wb.starving, m_starve);
      check("rorw", wb.RorW, exp_q.size() != 0);
      if (wb.RorW && exp_q.size() != 0) begin
        check("write", {wb.WriteReg, wb.WD}, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (wb.RorW) rf[wb.WriteReg] <= wb.WD;
  end

  initial begin
    logic ga, gb, oa, ob;
    logic pa, pb;
    logic [4:0] ra, rb;
    logic [31:0] da, db;
    logic [4:0] t2_a_tbl;
    logic [4:0] t2_s_tbl;

    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
`ifdef WB_BYPASS_EN
    wb.A1 = 5'd0; wb.A2 = 5'd0; wb.RD1_in = 32'd0; wb.RD2_in = 32'd0;
`endif
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_rorw", wb.RorW, 1'b0);
    check("rst_wreg", wb.WriteReg, 5'd0);
    check("rst_wd", wb.WD, 32'd0);
    check("rst_starving", wb.starving, 1'b0);
    wb.a_valid = 1'b1; wb.a_reg = 5'd4;
    #1;
    check("rst_a_ready", wb.a_ready, 1'b0);
    wb.a_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // A-only write reaches the file two edges after acceptance.
    cycle(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, ga, gb, oa, ob);
    check("t1_a_ready", oa, 1'b1);
    idle();
    @(negedge clk);
    check("t1_rf5", rf[5], 32'h11);

    // Persistent conflict: A, A, A, then B forced, then A again.
    t2_a_tbl = 5'b10111;
    t2_s_tbl = 5'b00100;
    pb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 5'd2, 32'h200 + k, pb, 5'd3, 32'h300, ga, gb, oa, ob);
      check("t2_a_ready", oa, t2_a_tbl[k]);
      if (ob) pb = 1'b0;
      @(posedge clk); #2;
      check("t2_starving", wb.starving, t2_s_tbl[k]);
    end
    idle();

    // $0 discard alongside a real A write; B must not start counting.
    cycle(1'b1, 5'd7, 32'h77, 1'b1, 5'd0, 32'hdead, ga, gb, oa, ob);
    check("t3_a_ready", oa, 1'b1);
    check("t3_b_ready", ob, 1'b1);
    for (int k = 0; k < MAX_WAIT - 1; k++) begin
      cycle(1'b1, 5'd8, 32'h80 + k, 1'b1, 5'd9, 32'h90, ga, gb, oa, ob);
    end
    check("t3_no_early_starve", wb.starving, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h90, ga, gb, oa, ob);
    idle();
    @(negedge clk);
    check("t3_rf0", rf[0], 32'd0);
    check("t3_rf7", rf[7], 32'h77);

    // Back-to-back A writes, one per cycle.
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1, 5'(k), 32'h1000 + k, 1'b0, 5'd0, 32'd0, ga, gb, oa, ob);
    end
    idle();
    idle();

`ifdef WB_BYPASS_EN
    cycle(1'b1, 5'd9, 32'hABCD, 1'b0, 5'd0, 32'd0, ga, gb, oa, ob);
    @(posedge clk); #2;
    wb.A1 = 5'd9; wb.RD1_in = 32'd0; wb.A2 = 5'd10; wb.RD2_in = 32'h55;
    #1;
    check("t6_rd1_bypass", wb.RD1_out, 32'hABCD);
    check("t6_rd2_pass", wb.RD2_out, 32'h55);
    wb.A1 = 5'd0; wb.RD1_in = 32'h1234;
    #1;
    check("t6_rd1_zero", wb.RD1_out, 32'h1234);
    idle();
`endif

    // Asynchronous reset while a write is registered: it is dropped.
    rf[6] = 32'h66;
    cycle(1'b1, 5'd6, 32'hbad6, 1'b0, 5'd0, 32'd0, ga, gb, oa, ob);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("t4_rorw", wb.RorW, 1'b0);
    check("t4_starving", wb.starving, 1'b0);
    check("t4_wreg", wb.WriteReg, 5'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check("t4_rf6", rf[6], 32'h66);
    reset = 1'b0;

    // Random traffic with held requests, $0 targets included.
    pa = 1'b0; pb = 1'b0;
    ra = 5'd0; rb = 5'd0; da = 32'd0; db = 32'd0;
    repeat (300) begin
      if (!pa && $urandom_range(0, 3) != 0) begin
        pa = 1'b1; ra = 5'($urandom_range(0, 7)); da = $urandom;
      end
      if (!pb && $urandom_range(0, 1) != 0) begin
        pb = 1'b1; rb = 5'($urandom_range(0, 7)); db = $urandom;
      end
      cycle(pa, ra, da, pb, rb, db, ga, gb, oa, ob);
      if (ga) pa = 1'b0;
      if (gb) pb = 1'b0;
    end
    idle();
    idle();
    @(negedge clk);
    check("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
